// File: rtl/fpmul_arb_pkg.sv
// fpmul_arb_pkg
//   Shared definitions for the floating-point multiplier arbiter:
//   - FEX_W       : width of the multiplier exception-flag bus
//   - arb_state_t : RUN / DRAIN / HALT control states
//   - ptr_width() : index width needed to address n requesters (minimum 1)
package fpmul_arb_pkg;

  localparam int FEX_W = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } arb_state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin selector. The search starts at index
//   ptr and wraps around, so the first asserted request at or after ptr wins.
//   Ports:
//     req   [NREQ-1:0]  : request vector
//     ptr   [PTR_W-1:0] : highest-priority index for this cycle
//     grant [NREQ-1:0]  : one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic found;

  // Walk the priority order ptr, ptr+1, ... and take the first hit.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter
//   Shares one pipelined floating-point multiplier between NREQ requesters.
//   A round-robin arbiter grants one requester per cycle; the granted index
//   travels through a LATENCY-deep tag pipe alongside the multiplier so the
//   registered result can be steered back to its owner. flush stops new
//   grants, lets in-flight work drain, then parks in HALT until flush drops.
//
//   Optional build macro: FPMUL_ARB_ERRCHK_EN adds a sticky err output that
//   flags mul_done arriving without a matching tag, or a tag leaving the
//   pipe without mul_done.
//
//   Ports:
//     clk, rst                   : clock, synchronous active-high reset
//     req_valid/req_a/req_b      : per-requester request and packed operands
//     req_ready                  : one-hot grant
//     resp_valid                 : one-hot, one-cycle result strobe
//     resp_result/resp_fex       : shared result and exception flags (held)
//     mul_valid/mul_a/mul_b      : issue side of the multiplier
//     mul_result/mul_fex/mul_done: return side of the multiplier
//     flush                      : stop granting and drain
//     busy                       : any operation in flight
//     err (optional)             : sticky tag/done mismatch flag
module fpmul_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int NREQ    = 4,
  parameter int LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_a,
  input  logic [NREQ*DWIDTH-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DWIDTH-1:0]      resp_result,
  output logic [FEX_W-1:0]       resp_fex,
  output logic                   mul_valid,
  output logic [DWIDTH-1:0]      mul_a,
  output logic [DWIDTH-1:0]      mul_b,
  input  logic [DWIDTH-1:0]      mul_result,
  input  logic [FEX_W-1:0]       mul_fex,
  input  logic                   mul_done,
  input  logic                   flush,
`ifdef FPMUL_ARB_ERRCHK_EN
  output logic                   err,
`endif
  output logic                   busy
);

  localparam int PTR_W = ptr_width(NREQ);

  arb_state_t state_reg, state_next;

  logic [PTR_W-1:0]  rr_ptr_reg;
  logic              grant_en;
  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic              xfer;

  logic [LATENCY-1:0] tag_vld_reg;
  logic [PTR_W-1:0]   tag_idx_reg [LATENCY];
  logic               tag_out_vld;
  logic [PTR_W-1:0]   tag_out_idx;

  logic [NREQ-1:0]   resp_valid_reg;
  logic [DWIDTH-1:0] resp_result_reg;
  logic [FEX_W-1:0]  resp_fex_reg;

  logic [DWIDTH-1:0] a_masked [NREQ];
  logic [DWIDTH-1:0] b_masked [NREQ];

  // Grants are gated by flush directly so they stop in the same cycle flush
  // rises, and by rst so no issue leaks out while the block is being reset.
  assign grant_en = (state_reg == RUN) && !flush && !rst;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid & {NREQ{grant_en}}),
    .ptr   (rr_ptr_reg),
    .grant (grant)
  );

  // grant is a subset of req_valid, so any grant bit is a transfer.
  assign xfer      = |grant;
  assign req_ready = grant;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_idx = PTR_W'(i);
    end
  end

  // One-hot AND-OR operand mux; zero when nothing is granted.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_opmask
      assign a_masked[gi] = {DWIDTH{grant[gi]}} & req_a[gi*DWIDTH +: DWIDTH];
      assign b_masked[gi] = {DWIDTH{grant[gi]}} & req_b[gi*DWIDTH +: DWIDTH];
    end
  endgenerate

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      mul_a = mul_a | a_masked[i];
      mul_b = mul_b | b_masked[i];
    end
  end

  assign mul_valid = xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (xfer) begin
      rr_ptr_reg <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Tag pipe: entry k holds the issue from k+1 cycles ago, so the last
  // entry lines up with mul_done for that issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_reg <= '0;
      for (int i = 0; i < LATENCY; i++) tag_idx_reg[i] <= '0;
    end else begin
      tag_vld_reg[0] <= xfer;
      tag_idx_reg[0] <= gnt_idx;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld_reg[i] <= tag_vld_reg[i-1];
        tag_idx_reg[i] <= tag_idx_reg[i-1];
      end
    end
  end

  assign tag_out_vld = tag_vld_reg[LATENCY-1];
  assign tag_out_idx = tag_idx_reg[LATENCY-1];
  assign busy        = |tag_vld_reg;

  // A done without a live tag (e.g. a result of an op issued before reset)
  // is dropped and leaves the result bus untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_reg  <= '0;
      resp_result_reg <= '0;
      resp_fex_reg    <= '0;
    end else begin
      resp_valid_reg <= '0;
      if (mul_done && tag_out_vld) begin
        resp_valid_reg  <= NREQ'(1) << tag_out_idx;
        resp_result_reg <= mul_result;
        resp_fex_reg    <= mul_fex;
      end
    end
  end

  assign resp_valid  = resp_valid_reg;
  assign resp_result = resp_result_reg;
  assign resp_fex    = resp_fex_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if (!busy) state_next = HALT;
      HALT:    if (!flush) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

`ifdef FPMUL_ARB_ERRCHK_EN
  logic err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (mul_done != tag_out_vld) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_fpmul_arbiter.sv
module tb_fpmul_arbiter;
  import fpmul_arb_pkg::*;

  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR-1:0]     req_ready, resp_valid;
  logic [DW-1:0]     resp_result;
  logic [2:0]        resp_fex;
  logic              mul_valid;
  logic [DW-1:0]     mul_a, mul_b, mul_result;
  logic [2:0]        mul_fex;
  logic              mul_done;
  logic              flush;
  logic              busy;
`ifdef FPMUL_ARB_ERRCHK_EN
  logic              err;
`endif

  fpmul_arbiter #(.DWIDTH(DW), .NREQ(NR), .LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_fex    (resp_fex),
    .mul_valid   (mul_valid),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_result  (mul_result),
    .mul_fex     (mul_fex),
    .mul_done    (mul_done),
    .flush       (flush),
`ifdef FPMUL_ARB_ERRCHK_EN
    .err         (err),
`endif
    .busy        (busy)
  );

  // Single-precision multiply for normal operands, truncating; fex[0]=inexact.
  function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    logic [8:0]  e;
    logic        lost;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (p[47]) begin
      m = p[46:24]; lost = |p[23:0];
      e = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd126;
    end else begin
      m = p[45:23]; lost = |p[22:0];
      e = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
    end
    return {2'b00, lost, a[31] ^ b[31], e[7:0], m};
  endfunction

  // Multiplier stand-in: fixed LAT-cycle pipeline, not cleared by rst.
  logic [LAT-1:0] pv = '0;
  logic [31:0]    pr [LAT];
  logic [2:0]     pf [LAT];
  logic           force_done = 1'b0;

  always_ff @(posedge clk) begin
    pv    <= {pv[LAT-2:0], mul_valid};
    pr[0] <= fmul(mul_a, mul_b)[31:0];
    pf[0] <= fmul(mul_a, mul_b)[34:32];
    for (int i = 1; i < LAT; i++) begin
      pr[i] <= pr[i-1];
      pf[i] <= pf[i-1];
    end
  end

  assign mul_done   = pv[LAT-1] | force_done;
  assign mul_result = pr[LAT-1];
  assign mul_fex    = pf[LAT-1];

  // Reference model state
  typedef struct {
    int          ic;
    int          idx;
    logic [31:0] res;
    logic [2:0]  fex;
  } pend_t;

  pend_t       pend [$];
  int          cyc = 0;
  int          m_ptr = 0;
  int          m_mode = 0;     // 0 granting, 1 draining, 2 parked
  logic [31:0] m_res = '0;
  logic [2:0]  m_fex = '0;
  logic [31:0] opa [NR];
  logic [31:0] opb [NR];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      opa[i] = rnd_fp();
      opb[i] = rnd_fp();
    end
  endtask

  // One clock cycle: drive, check against model, advance model.
  task automatic step(input logic [NR-1:0] v, input logic fl, input logic r);
    int          g;
    int          idx;
    logic [NR-1:0] e_rdy, e_rv;
    logic        e_busy;
    logic [31:0] ea, eb;
    logic [34:0] pm;
    req_valid = v;
    flush     = fl;
    rst       = r;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = opa[i];
      req_b[i*DW +: DW] = opb[i];
    end
    #3;
    g = -1;
    if (!r && m_mode == 0 && !fl) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    e_rdy = '0; ea = '0; eb = '0;
    if (g >= 0) begin
      e_rdy[g] = 1'b1; ea = opa[g]; eb = opb[g];
    end
    e_rv = '0; e_busy = 1'b0;
    foreach (pend[j]) begin
      if (pend[j].ic + LAT + 1 == cyc) begin
        e_rv[pend[j].idx] = 1'b1;
        m_res = pend[j].res;
        m_fex = pend[j].fex;
      end
      if (pend[j].ic < cyc && cyc <= pend[j].ic + LAT) e_busy = 1'b1;
    end
    chk("req_ready",   req_ready,   e_rdy);
    chk("mul_valid",   mul_valid,   g >= 0);
    chk("mul_a",       mul_a,       ea);
    chk("mul_b",       mul_b,       eb);
    chk("resp_valid",  resp_valid,  e_rv);
    chk("resp_result", resp_result, m_res);
    chk("resp_fex",    resp_fex,    m_fex);
    chk("busy",        busy,        e_busy);
    $display("cyc=%0d v=%b fl=%b rst=%b rdy=%b rv=%b res=%h busy=%b",
             cyc, v, fl, r, req_ready, resp_valid, resp_result, busy);
    if (r) begin
      pend.delete();
      m_ptr = 0; m_mode = 0; m_res = '0; m_fex = '0;
    end else begin
      if (g >= 0) begin
        pm = fmul(ea, eb);
        pend.push_back('{ic: cyc, idx: g, res: pm[31:0], fex: pm[34:32]});
        m_ptr = (g + 1) % NR;
      end
      case (m_mode)
        0: if (fl) m_mode = 1;
        1: if (!e_busy) m_mode = 2;
        default: if (!fl) m_mode = 0;
      endcase
      while (pend.size() > 0 && pend[0].ic + LAT + 1 <= cyc) void'(pend.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rand_ops();
    repeat (2) @(posedge clk);
    #1;

    // Single op from requester 0: 1.0 * 2.0 -> 2.0 four cycles later
    step('0, 1'b0, 1'b0);
    opa[0] = 32'h3F800000; opb[0] = 32'h40000000;
    step(4'b0001, 1'b0, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);
    chk("r30_valid",  resp_valid,  4'b0001);
    chk("r30_result", resp_result, 32'h40000000);
    repeat (2) step('0, 1'b0, 1'b0);

    // All four requesters, 8 back-to-back cycles from rr_ptr=0
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step(4'b1111, 1'b0, 1'b0);
    end
    repeat (5) step('0, 1'b0, 1'b0);

    // rr_ptr=2 with requesters 1 and 3 pending: 3 wins, then 1
    step('0, 1'b0, 1'b1);
    rand_ops();
    step(4'b0010, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    repeat (5) step('0, 1'b0, 1'b0);

    // Three issues then flush: drain, park, resume
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step(4'b1111, 1'b0, 1'b0);
    end
    repeat (6) step(4'b1111, 1'b1, 1'b0);
    chk("halt_state", dut.state_reg, HALT);
    chk("halt_busy",  busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step(4'b1111, 1'b0, 1'b0);
    end
    repeat (5) step('0, 1'b0, 1'b0);

    // Reset one cycle after an issue: the op must vanish
    rand_ops();
    step(4'b0100, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    repeat (5) step('0, 1'b0, 1'b0);

    // Random traffic with occasional flush bursts
    begin
      int fl_cnt = 0;
      for (int i = 0; i < 300; i++) begin
        rand_ops();
        if (fl_cnt == 0 && $urandom_range(0, 30) == 0) fl_cnt = $urandom_range(2, 8);
        step(4'($urandom_range(0, 15)), fl_cnt > 0, 1'b0);
        if (fl_cnt > 0) fl_cnt--;
      end
    end
    repeat (6) step('0, 1'b0, 1'b0);

`ifdef FPMUL_ARB_ERRCHK_EN
    chk("err_idle", err, 1'b0);
    force_done = 1'b1;
    step('0, 1'b0, 1'b0);
    force_done = 1'b0;
    chk("err_set", err, 1'b1);
    repeat (3) step('0, 1'b0, 1'b0);
    chk("err_sticky", err, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("err_clear", err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpmul_arbiter.md
FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter LATENCY, default 3, multiplier valid-to-done cycles.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-007 SHALL have port req_a / req_b  input  NREQ*DWIDTH  operands, requester i at bits [i*DWIDTH +: DWIDTH].
REQ-008 SHALL have port req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
REQ-009 SHALL have port resp_valid  output  NREQ  one-hot, one-cycle result strobe to the owning requester.
REQ-010 SHALL have port resp_result  output  DWIDTH  shared result bus; resp_fex  output  3  shared exception flags.
REQ-011 SHALL have port mul_valid  output  1, mul_a / mul_b  output  DWIDTH, driving the multiplier.
REQ-012 SHALL have port mul_result  input  DWIDTH, mul_fex  input  3, mul_done  input  1, returning from the multiplier.
REQ-013 SHALL have port flush  input  1  stop granting and drain; busy  output  1  any operation in flight.

Function
REQ-014 SHALL grant at most one requester per cycle, selected combinationally by round-robin from pointer rr_ptr.
REQ-015 SHALL advance rr_ptr to (granted index + 1) mod NREQ after each transfer, and hold it when no transfer occurs.
REQ-016 SHALL drive mul_valid=1 and mul_a/mul_b from the granted requester in the transfer cycle, else mul_valid=0 and mul_a/mul_b=0.
REQ-017 SHALL push the granted index and a valid bit into a LATENCY-deep tag shift register every cycle (bubble when no transfer).
REQ-018 SHALL, when mul_done=1, register mul_result/mul_fex into resp_result/resp_fex and assert resp_valid[tag] for one cycle; total request-to-response latency LATENCY+1.
REQ-019 SHALL hold resp_result/resp_fex at their last value while resp_valid=0.
REQ-020 SHALL implement states RUN, DRAIN, HALT: RUN->DRAIN when flush=1; DRAIN->HALT when the tag register holds no valid entry; HALT->RUN when flush=0.
REQ-021 SHALL drive req_ready=0 in DRAIN and HALT; in-flight responses in DRAIN SHALL still be delivered.
REQ-022 SHALL assert busy whenever any tag-register valid bit is set.
REQ-023 SHALL sustain back-to-back issue: one transfer every cycle when requests are pending in RUN.

Reset
REQ-024 SHALL, on rst, clear req_ready, resp_valid, resp_result, resp_fex, mul_valid, mul_a, mul_b, busy, tag register, rr_ptr (0), state (RUN).
REQ-025 SHALL, on rst mid-operation, discard in-flight tags; mul_done in the first LATENCY cycles after rst SHALL produce no resp_valid.

Configuration
REQ-026 SHALL, with FPMUL_ARB_ERRCHK_EN defined, add output err (1 bit, sticky until rst) set when mul_done=1 with no valid tag or when a valid tag exits without mul_done.
REQ-027 SHALL, without FPMUL_ARB_ERRCHK_EN, omit port err and its logic; mismatched mul_done SHALL be ignored.

Structure
REQ-028 SHALL place the state enum (RUN/DRAIN/HALT) and FEX_W=3 in package fpmul_arb_pkg.
REQ-029 SHALL implement the round-robin selection as sub-module rr_arbiter (inputs req, ptr; output one-hot grant).

Verification
REQ-030 Bench SHALL connect the team fpmul (DWIDTH=32) and check: requester 0 sends 0x3F800000*0x40000000 -> resp_valid=4'b0001, resp_result=0x40000000 exactly 4 cycles later.
REQ-031 All four requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3, each resp_valid matches issue order, one response per cycle.
REQ-032 Requesters 1 and 3 valid, rr_ptr=2 -> grant 3 first, then 1.
REQ-033 Issue 3 ops then flush=1 -> req_ready=0 immediately, 3 responses delivered, busy falls, state HALT; flush=0 -> grants resume.
REQ-034 rst asserted 1 cycle after an issue -> no resp_valid for that op, all outputs zero.
REQ-035 With FPMUL_ARB_ERRCHK_EN, force mul_done=1 with empty pipeline -> err=1 next cycle, remains until rst.
